rfi_frame_buffer: RTL and testbench

Double-buffered capture and readout stage for the per-channel accumulated power and correlation stream produced by the RFI detection pipeline. It collects one complete spectrum frame of 2^CHANNEL_ADDR channels into a write bank. It then hands the full bank to a software/register-side reader through a ready/acknowledge handshake while the next frame fills the other bank. Frames that complete while the reader still holds a bank are dropped and counted.

---
 rtl/rfi_frame_buffer.sv | 171 +++++++++++++++++
 tb/tb_rfi_frame_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rfi_frame_buffer.sv
// rtl/rfi_frame_buffer.sv - double-buffered spectrum frame capture with ready/ack readout (optional peak tracker: RFI_FRAME_PEAK_EN)
module rfi_frame_buffer #(
  parameter int DIN_WIDTH    = 18,
  parameter int CHANNEL_ADDR = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIN_WIDTH-1:0]    pow_data,
  input  logic [DIN_WIDTH-1:0]    corr_data,
  input  logic                    din_valid,
  input  logic                    cnt_rst,
  input  logic                    rd_en,
  input  logic [CHANNEL_ADDR-1:0] rd_addr,
  output logic [DIN_WIDTH-1:0]    rd_pow,
  output logic [DIN_WIDTH-1:0]    rd_corr,
  output logic                    rd_valid,
  output logic                    frame_ready,
  input  logic                    frame_ack,
  output logic [31:0]             frame_count,
  output logic [15:0]             drop_count,
  output logic                    overflow
`ifdef RFI_FRAME_PEAK_EN
  ,
  output logic [DIN_WIDTH-1:0]    peak_pow,
  output logic [CHANNEL_ADDR-1:0] peak_chan
`endif
);

  localparam int N = 1 << CHANNEL_ADDR;
  localparam logic [CHANNEL_ADDR-1:0] LAST_CHAN = '1;

  typedef enum logic {EMPTY, READY} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    wr_bank;
  logic [CHANNEL_ADDR-1:0] chan_cnt;
  logic                    wr_fire;
  logic                    complete;
  logic                    swap;
  logic                    drop;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [2*DIN_WIDTH-1:0]  mem [0:2*N-1];

  assign wr_fire     = din_valid & ~cnt_rst;
  assign complete    = wr_fire & (chan_cnt == LAST_CHAN);
  assign frame_ready = (state == READY);

  // Reader FSM next state: an ack is applied before a same-cycle completion.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    drop      = 1'b0;
    if (state == READY && frame_ack) begin
      state_nxt = EMPTY;
    end
    if (complete) begin
      if (state_nxt == EMPTY) begin
        swap      = 1'b1;
        state_nxt = READY;
      end else begin
        drop      = 1'b1;
      end
    end
  end

  // Reader FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Channel counter and write-bank selection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chan_cnt <= '0;
      wr_bank  <= 1'b0;
    end else begin
      if (cnt_rst) begin
        chan_cnt <= '0;
      end else if (din_valid) begin
        chan_cnt <= chan_cnt + 1'b1;
      end
      if (swap) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Handed-off and dropped frame statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (swap) begin
        frame_count <= frame_count + 32'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, chan_cnt}] <= {pow_data, corr_data};
    end
  end

  // Registered read from the bank not being written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pow   <= '0;
      rd_corr  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en & frame_ready;
      if (rd_en) begin
        {rd_pow, rd_corr} <= mem[{~wr_bank, rd_addr}];
      end
    end
  end

`ifdef RFI_FRAME_PEAK_EN
  logic [DIN_WIDTH-1:0]    cur_max;
  logic [CHANNEL_ADDR-1:0] cur_chan;
  logic                    take_new;
  logic [DIN_WIDTH-1:0]    cand_pow;
  logic [CHANNEL_ADDR-1:0] cand_chan;

  // Strict compare keeps the earliest channel on ties; channel 0 always seeds.
  always_comb begin
    take_new  = (chan_cnt == '0) || (pow_data > cur_max);
    cand_pow  = take_new ? pow_data : cur_max;
    cand_chan = take_new ? chan_cnt : cur_chan;
  end

  // Running per-frame maximum and the value published at each bank swap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_max   <= '0;
      cur_chan  <= '0;
      peak_pow  <= '0;
      peak_chan <= '0;
    end else begin
      if (cnt_rst || complete) begin
        cur_max  <= '0;
        cur_chan <= '0;
      end else if (wr_fire) begin
        cur_max  <= cand_pow;
        cur_chan <= cand_chan;
      end
      if (swap) begin
        peak_pow  <= cand_pow;
        peak_chan <= cand_chan;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rfi_frame_buffer.sv
// tb/tb_rfi_frame_buffer.sv - table-driven self-checking bench for rfi_frame_buffer
module tb_rfi_frame_buffer;

  localparam int DW = 18;
  localparam int CA = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pow_data, corr_data;
  logic          din_valid, cnt_rst, rd_en, frame_ack;
  logic [CA-1:0] rd_addr;
  logic [DW-1:0] rd_pow, rd_corr;
  logic          rd_valid, frame_ready, overflow;
  logic [31:0]   frame_count;
  logic [15:0]   drop_count;
`ifdef RFI_FRAME_PEAK_EN
  logic [DW-1:0] peak_pow;
  logic [CA-1:0] peak_chan;
`endif

  rfi_frame_buffer #(.DIN_WIDTH(DW), .CHANNEL_ADDR(CA)) dut (
    .clk(clk), .rst_n(rst_n), .pow_data(pow_data), .corr_data(corr_data),
    .din_valid(din_valid), .cnt_rst(cnt_rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_pow(rd_pow), .rd_corr(rd_corr), .rd_valid(rd_valid),
    .frame_ready(frame_ready), .frame_ack(frame_ack),
    .frame_count(frame_count), .drop_count(drop_count), .overflow(overflow)
`ifdef RFI_FRAME_PEAK_EN
    , .peak_pow(peak_pow), .peak_chan(peak_chan)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] pow;
    logic [DW-1:0] corr;
    logic          crst;
    logic          re;
    logic [CA-1:0] ra;
    logic          ack;
    logic          ex_ready;
    logic          ex_rv;
    logic [DW-1:0] ex_rp;
    logic [DW-1:0] ex_rc;
    logic [31:0]   ex_fc;
    logic [15:0]   ex_dc;
    logic          ex_ovf;
  } vec_t;

  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cf = 0, cd = 0;
  logic  co = 1'b0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic add(input logic v, input int pow, input int corr, input logic crst,
                     input logic re, input int ra, input logic ack,
                     input logic ready, input logic rv, input int rp, input int rc);
    vec_t t;
    t.v = v; t.pow = DW'(pow); t.corr = DW'(corr); t.crst = crst;
    t.re = re; t.ra = CA'(ra); t.ack = ack;
    t.ex_ready = ready; t.ex_rv = rv; t.ex_rp = DW'(rp); t.ex_rc = DW'(rc);
    t.ex_fc = 32'(cf); t.ex_dc = 16'(cd); t.ex_ovf = co;
    vecs.push_back(t);
  endtask

  task automatic idle();
    din_valid = 0; pow_data = 0; corr_data = 0; cnt_rst = 0;
    rd_en = 0; rd_addr = 0; frame_ack = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_ready"}, -1, 32'(frame_ready), 0);
    check({tag, "_rd_valid"},    -1, 32'(rd_valid), 0);
    check({tag, "_rd_pow"},      -1, 32'(rd_pow), 0);
    check({tag, "_rd_corr"},     -1, 32'(rd_corr), 0);
    check({tag, "_frame_count"}, -1, frame_count, 0);
    check({tag, "_drop_count"},  -1, 32'(drop_count), 0);
    check({tag, "_overflow"},    -1, 32'(overflow), 0);
`ifdef RFI_FRAME_PEAK_EN
    check({tag, "_peak_pow"},    -1, 32'(peak_pow), 0);
    check({tag, "_peak_chan"},   -1, 32'(peak_chan), 0);
`endif
  endtask

  initial begin
    // Basic frame then readback.
    add(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 20, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 30, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    cf = 1;
    add(1, 40, 4, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 1, a, 0, 1, 1, 10 * (a + 1), a + 1);
    // Ping-pong: ack mid-frame, next completion swaps.
    add(1, 50, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 60, 6, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 70, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cf = 2;
    add(1, 80, 8, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 1, a, 0, 1, 1, 50 + 10 * a, 5 + a);
    // Two dropped frames; held frame still reads back while they stream.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin cd = 1; co = 1'b1; end
      add(1, 90 + k, 9 + k, 0, 0, 0, 0, 1, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cd = 2;
      add(1, 110 + k, 13 + k, 0, 1, k, 0, 1, 1, 50 + 10 * k, 5 + k);
    end
    // Read on the ack cycle is still valid; read in EMPTY is not.
    add(0, 0, 0, 0, 1, 0, 1, 0, 1, 50, 5);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cf = 3;
      add(1, 120 + k, 17 + k, 0, 0, 0, 0, k == 3, 0, 0, 0);
    end
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 1, a, 0, 1, 1, 120 + a, 17 + a);
    // Ack coincident with completion: stays ready, counts, no drop.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cf = 4;
      add(1, 130 + k, 21 + k, 0, 0, 0, k == 3, 1, 0, 0, 0);
    end
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 1, a, 0, 1, 1, 130 + a, 21 + a);
    // Realign: partial frame discarded by cnt_rst (which beats a same-cycle valid).
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 140, 29, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 141, 30, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 999, 999, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cf = 5;
      add(1, 100 + k, 25 + k, 0, 0, 0, 0, k == 3, 0, 0, 0);
    end
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 1, a, 0, 1, 1, 100 + a, 25 + a);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      din_valid = vecs[i].v;  pow_data = vecs[i].pow; corr_data = vecs[i].corr;
      cnt_rst = vecs[i].crst; rd_en = vecs[i].re;     rd_addr = vecs[i].ra;
      frame_ack = vecs[i].ack;
      @(posedge clk);
      #1;
      check("frame_ready", i, 32'(frame_ready), 32'(vecs[i].ex_ready));
      check("rd_valid",    i, 32'(rd_valid),    32'(vecs[i].ex_rv));
      check("frame_count", i, frame_count,      vecs[i].ex_fc);
      check("drop_count",  i, 32'(drop_count),  32'(vecs[i].ex_dc));
      check("overflow",    i, 32'(overflow),    32'(vecs[i].ex_ovf));
      if (vecs[i].ex_rv) begin
        check("rd_pow",  i, 32'(rd_pow),  32'(vecs[i].ex_rp));
        check("rd_corr", i, 32'(rd_corr), 32'(vecs[i].ex_rc));
      end
    end

    // Reset mid-frame with a read pending: everything returns to zero.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle(); din_valid = 1; pow_data = DW'(200 + k); corr_data = DW'(k);
    end
    @(negedge clk);
    rst_n = 1'b0; rd_en = 1; din_valid = 1; pow_data = 202;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1; idle();

    // Fresh frame after reset; pow 5,9,9,2 also exercises the peak tie rule.
    for (int k = 0; k < 4; k++) begin
      int pv;
      pv = (k == 0) ? 5 : (k == 3) ? 2 : 9;
      @(negedge clk);
      idle(); din_valid = 1; pow_data = DW'(pv); corr_data = DW'(31 + k);
      @(posedge clk);
      #1;
      check("post_reset_ready", k, 32'(frame_ready), (k == 3) ? 1 : 0);
    end
    check("post_reset_fc", 4, frame_count, 1);
    check("post_reset_dc", 4, 32'(drop_count), 0);
    check("post_reset_ovf", 4, 32'(overflow), 0);
`ifdef RFI_FRAME_PEAK_EN
    check("peak_pow", 4, 32'(peak_pow), 9);
    check("peak_chan", 4, 32'(peak_chan), 1);
`endif
    @(negedge clk);
    idle(); rd_en = 1; rd_addr = 1;
    @(posedge clk);
    #1;
    check("post_reset_rv", 5, 32'(rd_valid), 1);
    check("post_reset_rp", 5, 32'(rd_pow), 9);
    check("post_reset_rc", 5, 32'(rd_corr), 32);
    @(negedge clk);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
